mem_wb_pipe_stage: RTL
======================

// Module: mem_wb_pipe_stage
// PURPOSE
//   Parametrised MEM/WB pipeline stage with a valid/ready handshake and a 2-entry skid buffer.
//   Carries ALU result, memory read data, destination register and WB control bits into write-back.
//   Blocks capture on a cache miss (hit=0) and supports a synchronous flush.
//   Saturating stall counter for miss cycles. Sits between the data-cache/MEM stage and the WB mux.
// PARAMETERS
//   DATA_W   32  width of ALU result and memory data
//   ADDR_W   5   width of destination register index
//   CTRL_W   2   width of WB control bundle (bit0 = RegWrite, bit1 = MemToReg)
//   CNT_W    16  width of stall counter
// PORTS
//   clk          in   1       rising-edge clock
//   rst          in   1       synchronous, active-high reset
//   in_valid     in   1       MEM stage presents a valid instruction
//   in_ready     out  1       stage can accept (registered)
//   hit          in   1       cache hit; memory data valid this cycle
//   flush        in   1       discard all held entries
//   alu_in       in   DATA_W  ALU result
//   mem_in       in   DATA_W  memory read data
//   wreg_in      in   ADDR_W  destination register
//   ctrl_in      in   CTRL_W  WB control bits
//   out_valid    out  1       WB stage entry valid
//   out_ready    in   1       WB stage consumes entry
//   alu_out      out  DATA_W  held ALU result
//   mem_out      out  DATA_W  held memory data
//   wreg_out     out  ADDR_W  held destination register
//   ctrl_out     out  CTRL_W  held WB control; 0 whenever out_valid=0
//   stall_cnt    out  CNT_W   count of miss-stall cycles
// BEHAVIOUR
//   - Reset (rst=1 at posedge): state EMPTY; in_ready=1; out_valid=0; all data outputs, ctrl_out and stall_cnt = 0.
//   - accept = in_valid & in_ready & (hit==1). pop = out_valid & out_ready.
//   - State machine (main reg M drives outputs; skid reg S):
//       EMPTY: accept -> load M, ONE. Otherwise stay.
//       ONE:   accept & pop -> load M, ONE. accept & !pop -> load S, TWO.
//              !accept & pop -> EMPTY (ctrl_out <= 0). Else hold.
//       TWO:   in_ready=0. pop -> M<=S, ONE. Else hold.
//   - in_ready next = (next_state != TWO). Strict FIFO order; no entry is dropped or duplicated.
//   - Latency: accepted data visible on outputs the cycle after accept when the stage is EMPTY.
//   - Data outputs hold their last value when out_valid=0; only ctrl_out is forced to 0.
//   - flush (priority over accept/pop, below rst): state EMPTY, out_valid=0, ctrl_out=0, in_ready=1.
//     A same-cycle input is discarded. stall_cnt is unaffected.
//   - stall_cnt increments by 1 on each cycle with in_valid & in_ready & hit!=1.
//     Saturates at 2^CNT_W-1; cleared only by rst.
//   - hit is sampled only when in_valid & in_ready. A miss never modifies M or S.
//   - Reset mid-transfer drops both entries; behaviour is identical to power-up.
// TESTING
//   1. Reset, then in_valid=1, hit=1, alu_in=0x11, wreg_in=3, ctrl_in=2'b01, out_ready=1
//      -> next cycle out_valid=1, alu_out=0x11, wreg_out=3, ctrl_out=01.
//   2. out_ready=0, push entries A (0xA) and B (0xB)
//      -> in_ready=0 after B; release out_ready -> A then B on consecutive cycles, in_ready=1 again.
//   3. in_valid=1 with hit=0 for 5 cycles, then hit=1
//      -> no out_valid during the miss, stall_cnt=5, entry appears once after the hit.
//   4. State TWO, assert flush together with in_valid/hit
//      -> next cycle out_valid=0, ctrl_out=0, in_ready=1, and the incoming entry is absent.
//   5. CNT_W=4, hold a miss for 20 cycles -> stall_cnt=15 (saturated).
//   6. Assert rst while in state TWO with out_ready=0
//      -> all outputs 0, in_ready=1; no stale entry appears afterwards.

Source files
------------

// File: rtl/mem_wb_pipe_stage.sv
// MEM/WB stage with 2-entry skid buffer; accepted data is visible one cycle after accept.
// Backpressure: registered in_ready drops while both entries are held; a cache miss blocks capture.
module mem_wb_pipe_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CTRL_W = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              hit,
    input  logic              flush,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [DATA_W-1:0] mem_in,
    input  logic [ADDR_W-1:0] wreg_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] mem_out,
    output logic [ADDR_W-1:0] wreg_out,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [CNT_W-1:0]  stall_cnt
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t            state_q, state_d;
    logic              in_ready_q;
    logic [DATA_W-1:0] m_alu_q, m_mem_q, s_alu_q, s_mem_q;
    logic [ADDR_W-1:0] m_wreg_q, s_wreg_q;
    logic [CTRL_W-1:0] m_ctrl_q, s_ctrl_q;
    logic [CNT_W-1:0]  stall_q;

    logic accept, pop, miss;
    logic load_m, load_s, shift_s, clr_ctrl;

    always_comb begin
        accept   = in_valid & in_ready_q & hit;
        pop      = (state_q != EMPTY) & out_ready;
        miss     = in_valid & in_ready_q & ~hit;
        state_d  = state_q;
        load_m   = 1'b0;
        load_s   = 1'b0;
        shift_s  = 1'b0;
        clr_ctrl = 1'b0;
        if (flush) begin
            state_d  = EMPTY;
            clr_ctrl = 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        load_m  = 1'b1;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        load_m = 1'b1;
                    end else if (accept) begin
                        load_s  = 1'b1;
                        state_d = TWO;
                    end else if (pop) begin
                        clr_ctrl = 1'b1;
                        state_d  = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        shift_s = 1'b1;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            m_alu_q    <= '0;
            m_mem_q    <= '0;
            m_wreg_q   <= '0;
            m_ctrl_q   <= '0;
            s_alu_q    <= '0;
            s_mem_q    <= '0;
            s_wreg_q   <= '0;
            s_ctrl_q   <= '0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != TWO);
            // Data fields keep their last value when draining; only ctrl is zeroed.
            if (load_m) begin
                m_alu_q  <= alu_in;
                m_mem_q  <= mem_in;
                m_wreg_q <= wreg_in;
                m_ctrl_q <= ctrl_in;
            end else if (shift_s) begin
                m_alu_q  <= s_alu_q;
                m_mem_q  <= s_mem_q;
                m_wreg_q <= s_wreg_q;
                m_ctrl_q <= s_ctrl_q;
            end else if (clr_ctrl) begin
                m_ctrl_q <= '0;
            end
            if (load_s) begin
                s_alu_q  <= alu_in;
                s_mem_q  <= mem_in;
                s_wreg_q <= wreg_in;
                s_ctrl_q <= ctrl_in;
            end
            if (miss && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign alu_out   = m_alu_q;
    assign mem_out   = m_mem_q;
    assign wreg_out  = m_wreg_q;
    assign ctrl_out  = m_ctrl_q;
    assign stall_cnt = stall_q;

endmodule
